first_ring_buffer: RTL and testbench
====================================

FIRST_RING_BUFFER -- requirements
Module: first_ring_buffer

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, the bit width of one data word.
REQ-002 The module SHALL have parameter NUM_LANE, default 2, the number of words accepted per write beat.
REQ-003 The module SHALL have parameter BURST_LENGTH, default 32, the number of write beats of storage; DEPTH = NUM_LANE*BURST_LENGTH words.
REQ-004 Port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 Port rst, input, 1, reset; synchronous, active-high.
REQ-006 Port wen, input, 1, write request for one beat of NUM_LANE words.
REQ-007 Port ren, input, 1, read request for one word; downstream drives it as "downstream not full".
REQ-008 Port din, input, NUM_LANE x DATA_WIDTH packed array, write beat; lane 0 is the oldest word.
REQ-009 Port valid, output, 1, dout carries a newly popped word this cycle; usable directly as the downstream write enable.
REQ-010 Port dout, output, DATA_WIDTH, registered output word.

Function
REQ-011 Storage SHALL be a circular buffer of DEPTH words with write pointer, read pointer (each clog2(DEPTH) bits) and an occupancy count of clog2(DEPTH+1) bits.
REQ-012 Write accepted when wen=1 and (DEPTH - count) >= NUM_LANE: din[k] stored at (wptr+k) mod DEPTH for k=0..NUM_LANE-1; wptr advances by NUM_LANE mod DEPTH.
REQ-013 Write with fewer than NUM_LANE free words SHALL be dropped entirely (no partial beat, pointers and count unchanged).
REQ-014 Read accepted when ren=1 and count>0 (count at the start of the cycle): dout <= mem[rptr], valid <= 1, rptr advances by 1 mod DEPTH.
REQ-015 Otherwise valid <= 0 and dout holds its previous value.
REQ-016 Read latency: word leaves on the cycle after the accepted read; one word per cycle max throughput.
REQ-017 No write-to-read bypass: a word written in cycle N is readable no earlier than cycle N+1 (first valid at N+2).
REQ-018 Simultaneous accepted read and write SHALL both occur; count <= count + NUM_LANE - 1.
REQ-019 Read on empty SHALL have no effect beyond valid <= 0; pointer wrap-around SHALL be seamless at DEPTH-1 -> 0.
REQ-020 Words SHALL emerge in strict write order: beat order first, lane index within beat.

Reset
REQ-021 When rst=1 at a rising edge: wptr=0, rptr=0, count=0, valid=0, dout=0; memory contents need not be cleared.
REQ-022 Reset mid-operation SHALL discard all stored words; any wen/ren in the reset cycle is ignored.

Structure
REQ-023 DEPTH and pointer widths SHALL be local parameters derived from module parameters; no shared package is required.
REQ-024 Implemented as a single module with no sub-modules; memory inferred as a register array with NUM_LANE write ports and one read port.

Verification
REQ-025 Reset then wen=1 one cycle with din={lane1=0x22,lane0=0x11}, ren=1 held -> valid=1 with dout=0x11 two cycles after the write, then dout=0x22, then valid=0.
REQ-026 Fill: 32 consecutive beats (NUM_LANE=2) with ren=0 -> count=64; a 33rd beat is dropped; draining yields exactly 64 words in order, 33rd beat absent.
REQ-027 Empty read: ren=1 after reset with no writes -> valid stays 0, dout stays 0.
REQ-028 Concurrent: continuous wen and ren for 100 cycles with incrementing data -> output sequence strictly incrementing, pointers wrap past DEPTH without loss, count grows by 1 per cycle until full, then writes drop.
REQ-029 Backpressure: ren toggling 1/0 while 4 beats are stored -> valid only on cycles following ren=1, 8 words in order.
REQ-030 Reset asserted with 10 words stored -> next cycle valid=0, dout=0; subsequent reads return nothing until new writes.

Source files
------------

// File: rtl/first_ring_buffer_pkg.sv
// rtl/first_ring_buffer_pkg.sv - shared helpers for the first_ring_buffer block
//
// Purpose : modular pointer arithmetic used by the ring buffer. DEPTH is not
//           required to be a power of two, so wrap-around is computed with an
//           explicit modulo instead of relying on pointer overflow.
// Ports   : none (package)
package first_ring_buffer_pkg;

   // (base + inc) mod depth, evaluated in 32-bit unsigned arithmetic.
   function automatic int unsigned wrap_add(input int unsigned base,
                                            input int unsigned inc,
                                            input int unsigned depth);
      return (base + inc) % depth;
   endfunction

endpackage

// File: rtl/first_ring_buffer.sv
// rtl/first_ring_buffer.sv - multi-lane write, single-word read circular buffer
//
// Purpose : accepts beats of NUM_LANE words and emits them one word per cycle
//           in write order (beat order, then lane index). Storage is
//           NUM_LANE*BURST_LENGTH words. A beat is accepted only when the whole
//           beat fits; otherwise it is dropped.
// Ports   : clk   - single clock, rising edge
//           rst   - synchronous active-high reset
//           wen   - write one beat of NUM_LANE words
//           ren   - read one word (downstream "not full")
//           din   - write beat, lane 0 is the oldest word
//           valid - dout holds a newly popped word this cycle
//           dout  - registered output word
module first_ring_buffer
   import first_ring_buffer_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_LANE     = 2,
   parameter int BURST_LENGTH = 32
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 wen,
   input  logic                                 ren,
   input  logic [NUM_LANE-1:0][DATA_WIDTH-1:0]  din,
   output logic                                 valid,
   output logic [DATA_WIDTH-1:0]                dout
);

   localparam int DEPTH = NUM_LANE * BURST_LENGTH;
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] LANE_C  = CNT_W'(NUM_LANE);
   localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_wptr;
   logic [PTR_W-1:0]      r_rptr;
   logic [CNT_W-1:0]      r_count;
   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_dout;

   logic [CNT_W-1:0]      w_free;
   logic                  w_wr_ok;
   logic                  w_rd_ok;
   logic [PTR_W-1:0]      w_waddr [NUM_LANE];
   logic [PTR_W-1:0]      w_wptr_next;

   // Both accept decisions use the occupancy at the start of the cycle, so a
   // read in the same cycle does not make room for a write.
   assign w_free  = DEPTH_C - r_count;
   assign w_wr_ok = wen && (w_free >= LANE_C);
   assign w_rd_ok = ren && (r_count != '0);

   always_comb begin
      for (int k = 0; k < NUM_LANE; k++) begin
         w_waddr[k] = PTR_W'(wrap_add(32'(r_wptr), 32'(k), 32'(DEPTH)));
      end
      w_wptr_next = PTR_W'(wrap_add(32'(r_wptr), 32'(NUM_LANE), 32'(DEPTH)));
   end

   // Memory is not reset; stale contents are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      if (!rst && w_wr_ok) begin
         for (int k = 0; k < NUM_LANE; k++) begin
            r_mem[w_waddr[k]] <= din[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_valid <= 1'b0;
         r_dout  <= '0;
      end else begin
         if (w_wr_ok) begin
            r_wptr <= w_wptr_next;
         end

         r_valid <= w_rd_ok;
         if (w_rd_ok) begin
            r_dout <= r_mem[r_rptr];
            r_rptr <= (r_rptr == LAST_C) ? '0 : r_rptr + 1'b1;
         end

         case ({w_wr_ok, w_rd_ok})
            2'b10:   r_count <= r_count + LANE_C;
            2'b01:   r_count <= r_count - 1'b1;
            2'b11:   r_count <= r_count + LANE_C - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign valid = r_valid;
   assign dout  = r_dout;

endmodule

// File: tb/tb_first_ring_buffer.sv
// tb/tb_first_ring_buffer.sv - self-checking bench for first_ring_buffer
module tb_first_ring_buffer;

   localparam int DW    = 32;
   localparam int NL    = 2;
   localparam int BL    = 32;
   localparam int DEPTH = NL * BL;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  wen;
   logic                  ren;
   logic [NL-1:0][DW-1:0] din;
   logic                  valid;
   logic [DW-1:0]         dout;

   first_ring_buffer #(
      .DATA_WIDTH   (DW),
      .NUM_LANE     (NL),
      .BURST_LENGTH (BL)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .wen   (wen),
      .ren   (ren),
      .din   (din),
      .valid (valid),
      .dout  (dout)
   );

   always #5 clk = ~clk;

   // Reference model: a word queue in write order, updated at each rising edge.
   logic [DW-1:0] q[$];
   logic          exp_valid = 1'b0;
   logic [DW-1:0] exp_dout  = '0;

   always @(posedge clk) begin
      int sz;
      if (rst) begin
         q.delete();
         exp_valid = 1'b0;
         exp_dout  = '0;
      end else begin
         sz = q.size();
         if (ren && sz > 0) begin
            exp_dout  = q.pop_front();
            exp_valid = 1'b1;
         end else begin
            exp_valid = 1'b0;
         end
         if (wen && (DEPTH - sz) >= NL) begin
            for (int k = 0; k < NL; k++) q.push_back(din[k]);
         end
      end
   end

   int n_checks = 0;
   int n_fail   = 0;
   int n_valid  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: wait past the rising edge, then compare DUT against the model.
   task automatic tick();
      @(negedge clk);
      chk("valid_vs_model", {31'd0, valid}, {31'd0, exp_valid});
      chk("dout_vs_model", dout, exp_dout);
      if (valid === 1'b1) n_valid++;
   endtask

   task automatic set_in(input logic r, input logic w, input logic re,
                         input logic [31:0] d0, input logic [31:0] d1);
      rst    = r;
      wen    = w;
      ren    = re;
      din[0] = d0;
      din[1] = d1;
   endtask

   task automatic do_reset();
      set_in(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      tick();
   endtask

   initial begin
      int n0;
      set_in(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      tick();
      chk("reset_valid", {31'd0, valid}, 32'd0);
      chk("reset_dout", dout, 32'd0);

      // Single beat with reads held: first word two cycles after the write.
      set_in(1'b0, 1'b1, 1'b1, 32'h11, 32'h22);
      tick();
      chk("basic_no_bypass", {31'd0, valid}, 32'd0);
      set_in(1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
      tick();
      chk("basic_w0_valid", {31'd0, valid}, 32'd1);
      chk("basic_w0_dout", dout, 32'h11);
      tick();
      chk("basic_w1_valid", {31'd0, valid}, 32'd1);
      chk("basic_w1_dout", dout, 32'h22);
      tick();
      chk("basic_end_valid", {31'd0, valid}, 32'd0);
      chk("basic_hold_dout", dout, 32'h22);

      // Reads on an empty buffer.
      do_reset();
      set_in(1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
      repeat (5) tick();
      chk("empty_valid", {31'd0, valid}, 32'd0);
      chk("empty_dout", dout, 32'd0);

      // Fill to capacity, one extra beat dropped, then drain.
      do_reset();
      for (int b = 0; b < BL + 1; b++) begin
         set_in(1'b0, 1'b1, 1'b0, 32'(2 * b), 32'(2 * b + 1));
         tick();
      end
      n0 = n_valid;
      set_in(1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
      repeat (DEPTH + 6) tick();
      chk("fill_word_count", 32'(n_valid - n0), 32'd64);
      chk("fill_last_word", dout, 32'd63);

      // Concurrent writes and reads with incrementing data, wrapping pointers.
      do_reset();
      for (int i = 0; i < 100; i++) begin
         set_in(1'b0, 1'b1, 1'b1, 32'(2 * i), 32'(2 * i + 1));
         tick();
      end
      set_in(1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
      repeat (DEPTH + 6) tick();

      // Backpressure: ren toggling with 4 beats stored.
      do_reset();
      for (int b = 0; b < 4; b++) begin
         set_in(1'b0, 1'b1, 1'b0, 32'(100 + 2 * b), 32'(101 + 2 * b));
         tick();
      end
      n0 = n_valid;
      for (int i = 0; i < 20; i++) begin
         set_in(1'b0, 1'b0, (i % 2) == 0, 32'd0, 32'd0);
         tick();
      end
      chk("bp_word_count", 32'(n_valid - n0), 32'd8);
      chk("bp_last_word", dout, 32'd107);

      // Reset with 10 words stored; wen/ren in the reset cycle are ignored.
      do_reset();
      for (int b = 0; b < 5; b++) begin
         set_in(1'b0, 1'b1, 1'b0, 32'(200 + b), 32'(300 + b));
         tick();
      end
      set_in(1'b1, 1'b1, 1'b1, 32'hdead, 32'hbeef);
      tick();
      chk("midrst_valid", {31'd0, valid}, 32'd0);
      chk("midrst_dout", dout, 32'd0);
      n0 = n_valid;
      set_in(1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
      repeat (5) tick();
      chk("midrst_no_words", 32'(n_valid - n0), 32'd0);

      // Randomized traffic with occasional resets.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         set_in(($urandom % 128) == 0, ($urandom % 3) != 0, ($urandom % 4) != 0,
                $urandom, $urandom);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
